// File: rtl/pe_row_drain_pkg.sv
// Shared constants for the PE-row read-out path: accumulator/output widths
// common with the PE array, index width helper and FSM state encodings.
package pe_row_drain_pkg;

   localparam int N_PE_DEF  = 8;
   localparam int ACC_W_DEF = 27;
   localparam int OUT_W_DEF = 8;
   localparam int SH_W_DEF  = 5;

   // Index width for an N-entry row; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W = idx_w(N_PE_DEF);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift,
// optional ReLU, then saturation into a signed OUT_W-bit range.
module requant_sat
   import pe_row_drain_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SH_W  = SH_W_DEF
) (
   input  logic signed [ACC_W-1:0] i_x,
   input  logic        [SH_W-1:0]  i_shift,
   input  logic                    i_relu,
   output logic signed [OUT_W-1:0] o_q
);

   localparam int WW = ACC_W + 1;
   localparam logic signed [WW-1:0] Q_MAX = WW'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [WW-1:0] Q_MIN = ~Q_MAX;

   // The rounding bit only exists while it fits below the sign bit; for larger
   // shifts the result is just the sign of the operand.
   function automatic logic signed [WW-1:0] round_shift(
      input logic signed [ACC_W-1:0] x,
      input logic        [SH_W-1:0]  s
   );
      logic signed [WW-1:0] wide;
      logic signed [WW-1:0] rnd;
      wide = WW'(x);
      rnd  = '0;
      if ((s != '0) && (int'(s) <= ACC_W))
         rnd[s - 1'b1] = 1'b1;
      return (wide + rnd) >>> s;
   endfunction

   function automatic logic signed [OUT_W-1:0] sat(
      input logic signed [WW-1:0] v,
      input logic                 relu
   );
      logic signed [WW-1:0] t;
      t = (relu && v[WW-1]) ? '0 : v;
      if (t > Q_MAX)
         return Q_MAX[OUT_W-1:0];
      else if (t < Q_MIN)
         return Q_MIN[OUT_W-1:0];
      else
         return t[OUT_W-1:0];
   endfunction

   logic signed [WW-1:0] w_shr;

   assign w_shr = round_shift(i_x, i_shift);
   assign o_q   = sat(w_shr, i_relu);

endmodule

// File: rtl/pe_row_drain.sv
// Read-out end of a systolic PE row: snapshots all accumulators on start and
// streams them out requantized, one element per valid/ready handshake.
module pe_row_drain
   import pe_row_drain_pkg::*;
#(
   parameter int N_PE  = N_PE_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SH_W  = SH_W_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [N_PE*ACC_W-1:0]         sum_in,
   input  logic [SH_W-1:0]               shift,
   input  logic                          relu_en,
   output logic                          busy,
   output logic signed [OUT_W-1:0]       out_data,
   output logic [idx_w(N_PE)-1:0]        out_idx,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          done
);

   localparam int W_IDX = idx_w(N_PE);

   logic [0:0]              r_state;
   logic signed [ACC_W-1:0] r_bank [N_PE];
   logic [SH_W-1:0]         r_shift;
   logic                    r_relu;
   logic [W_IDX-1:0]        r_idx;
   logic signed [OUT_W-1:0] r_data;
   logic                    r_valid;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_accept;
   logic                    w_xfer;
   logic                    w_last;
   logic [W_IDX-1:0]        w_nxt_idx;
   logic signed [ACC_W-1:0] w_q_x;
   logic [SH_W-1:0]         w_q_sh;
   logic                    w_q_relu;
   logic signed [OUT_W-1:0] w_q;

   assign w_accept  = (r_state == ST_IDLE) && start;
   assign w_xfer    = (r_state == ST_SEND) && r_valid && out_ready;
   assign w_last    = (r_idx == W_IDX'(N_PE - 1));
   assign w_nxt_idx = w_last ? '0 : r_idx + 1'b1;

   // One requantizer serves both the first element (straight from sum_in at
   // capture) and every following element (from the bank, with latched controls).
   always_comb begin
      w_q_x    = r_bank[w_nxt_idx];
      w_q_sh   = r_shift;
      w_q_relu = r_relu;
      if (r_state == ST_IDLE) begin
         w_q_x    = sum_in[ACC_W-1:0];
         w_q_sh   = shift;
         w_q_relu = relu_en;
      end
   end

   requant_sat #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
   ) u_requant (
      .i_x     (w_q_x),
      .i_shift (w_q_sh),
      .i_relu  (w_q_relu),
      .o_q     (w_q)
   );

   // Snapshot bank and latched controls carry data only, so no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int k = 0; k < N_PE; k++)
            r_bank[k] <= sum_in[k*ACC_W +: ACC_W];
         r_shift <= shift;
         r_relu  <= relu_en;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_idx   <= '0;
                  r_data  <= w_q;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            default: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx  <= w_nxt_idx;
                     r_data <= w_q;
                  end
               end
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign out_data  = r_data;
   assign out_idx   = r_idx;
   assign out_valid = r_valid;
   assign done      = r_done;

endmodule
